button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Conditions a raw, bouncing, asynchronous push-button (DE-board KEY, active-low) into clean control for the stopwatch FSM. It sits directly upstream of that FSM.
- Synchronises and debounces the raw button.
- Produces a stable debounced level (drives the FSM's i_run), single-cycle press/release strobes, and a single-cycle long-press strobe.

Parameters:
DEBOUNCE_CNT, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range ≥1
LONG_CNT, 50000000, cycles in debounced-pressed state before o_long fires (1 s at 50 MHz); legal range ≥1
PRESSED_LEVEL, 1'b0, raw input level meaning "pressed"

Ports:
clk  input  1  system clock, 50 MHz
reset_n  input  1  asynchronous active-low reset
i_btn  input  1  raw button, asynchronous to clk, may bounce
o_level  output  1  debounced level, same polarity as i_btn
o_press  output  1  1-cycle strobe on accepted press
o_release  output  1  1-cycle strobe on accepted release
o_long  output  1  1-cycle strobe after LONG_CNT cycles held; at most once per press

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low. All flops reset asynchronously.
- Reset values:
  - o_level = ~PRESSED_LEVEL.
  - o_press, o_release, o_long = 0.
  - state = RELEASED; counters = 0.
  - Both synchroniser flops = ~PRESSED_LEVEL, so no spurious press occurs on reset release.
- Synchroniser: 2-flop chain s1→s2. Only s2 feeds the FSM. Define p = (s2 == PRESSED_LEVEL).
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: if p, go to PRESS_WAIT with dcnt=0.
  - PRESS_WAIT:
    - if !p, return to RELEASED (glitch rejected, no strobe);
    - else if dcnt == DEBOUNCE_CNT-1, go to PRESSED, set o_level=PRESSED_LEVEL, pulse o_press, clear hcnt and the long-fired flag;
    - else dcnt++.
  - PRESSED:
    - if !p, go to RELEASE_WAIT with dcnt=0;
    - else if hcnt == LONG_CNT-1 and the fired flag is clear, pulse o_long and set the fired flag;
    - else hcnt++ (saturates once fired).
  - RELEASE_WAIT:
    - if p, return to PRESSED. hcnt and the fired flag are kept, not cleared. hcnt does not advance while in RELEASE_WAIT.
    - else if dcnt == DEBOUNCE_CNT-1, go to RELEASED, set o_level=~PRESSED_LEVEL, pulse o_release;
    - else dcnt++.
- Latency: a clean input change settling before rising edge 1 changes o_level and the matching strobe on edge DEBOUNCE_CNT+3. Of this, 2 edges are synchroniser delay and 1 edge is entering the wait state. o_long is asserted on edge E+LONG_CNT, where edge E is the one that entered PRESSED, assuming no bounce-back in between.
- Outputs: all registered, no combinational path from i_btn.
  - Strobes are high for exactly one cycle.
  - o_press and o_release are never high in the same cycle.
  - o_long and o_press cannot coincide, since LONG_CNT ≥ 1.
- Widths: dcnt is $clog2(DEBOUNCE_CNT+1) bits, hcnt is $clog2(LONG_CNT+1) bits. No wrap: dcnt is cleared on wait entry, and hcnt saturates.
- Boundaries:
  - A bounce shorter than DEBOUNCE_CNT cycles produces no output change.
  - The debounce count restarts on every re-entry to a wait state.
  - Holding the button indefinitely gives exactly one o_long.
  - reset_n asserted mid-press immediately forces reset values. If the button is still held after reset release, a new press is accepted after the full debounce time.
- Unused state encodings recover to RELEASED.

Decomposition:
- Shared package holds:
  - the 2-bit state encodings (RELEASED=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b10, RELEASE_WAIT=2'b11);
  - board constants CLK_HZ=50000000, DEBOUNCE_MS=20.
- One sub-module, sync_2ff: a 1-bit two-flop synchroniser with a reset-value parameter. It is reused for the other KEY/SW inputs.

Test Plan (DEBOUNCE_CNT=4, LONG_CNT=10, PRESSED_LEVEL=0):
1. Reset, i_btn held 1 for 20 cycles → o_level=1, no strobes at any time.
2. i_btn drops to 0 cleanly before edge 1 → o_level=0 and o_press=1 exactly at edge 7, o_press=0 at edge 8.
3. From released, i_btn pulses 0 for 3 cycles then returns to 1 (bounce) → o_level stays 1, o_press never asserted.
4. Hold i_btn=0 for 40 cycles → o_press at edge 7, o_long high only at edge 17, no second o_long. Then release cleanly → o_release at release-edge+7, o_level=1.
5. While PRESSED, i_btn glitches 1 for 2 cycles → no o_release, o_level stays 0, no extra o_press.
6. Hold pressed, assert reset_n=0 mid-press for 2 cycles while i_btn stays 0 → outputs immediately return to reset values (o_level=1). A fresh o_press follows at edge 7 after reset release.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared state encodings and board timing constants
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } btn_state_t;

  localparam int CLK_HZ      = 50000000;
  localparam int DEBOUNCE_MS = 20;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser with configurable reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronise and debounce a push-button into a clean
// level plus press, release and long-press strobes
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int   DEBOUNCE_CNT  = ms_to_cycles(DEBOUNCE_MS),
  parameter int   LONG_CNT      = CLK_HZ,
  parameter logic PRESSED_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam int HCNT_W = $clog2(LONG_CNT + 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(LONG_CNT - 1);

  logic              btn_s;
  logic              p;
  btn_state_t        state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              fired_q, fired_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  // Synchroniser idles at the released level so reset release never looks like a press
  sync_2ff #(
    .RESET_VAL(~PRESSED_LEVEL)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (i_btn),
    .q      (btn_s)
  );

  assign p = (btn_s == PRESSED_LEVEL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RELEASED;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      fired_q   <= 1'b0;
      level_q   <= ~PRESSED_LEVEL;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      fired_q   <= fired_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    fired_d   = fired_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    case (state_q)
      RELEASED: begin
        if (p) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!p) begin
          state_d = RELEASED;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d = PRESSED;
          level_d = PRESSED_LEVEL;
          press_d = 1'b1;
          hcnt_d  = '0;
          fired_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      PRESSED: begin
        if (!p) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end else if (hcnt_q == HCNT_LAST && !fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end else if (!fired_q) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        // A bounce back keeps the hold progress; only a full release clears it
        if (p) begin
          state_d = PRESSED;
        end else if (dcnt_q == DCNT_LAST) begin
          state_d   = RELEASED;
          level_d   = ~PRESSED_LEVEL;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        level_d = ~PRESSED_LEVEL;
        dcnt_d  = '0;
      end
    endcase
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed checks of button_conditioner
// against a run-length reference model
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 10;

  logic clk = 1'b0;
  logic reset_n;
  logic i_btn;
  logic o_level;
  logic o_press;
  logic o_release;
  logic o_long;

  int total = 0;
  int bad = 0;

  // reference model state: button history, run length of the synchronised value
  logic m_d1, m_d2, m_prev_p, m_run_p, m_lvl, m_fired;
  int   m_run, m_hold;
  logic e_press, e_release, e_long;

  int cyc, press_edge, release_edge, long_edge, n_long;

  button_conditioner #(
    .DEBOUNCE_CNT (D),
    .LONG_CNT     (L),
    .PRESSED_LEVEL(1'b0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_btn    (i_btn),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_release(o_release),
    .o_long   (o_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d1 = 1'b1; m_d2 = 1'b1;
    m_prev_p = 1'b0; m_run_p = 1'b0; m_run = 0;
    m_lvl = 1'b0; m_hold = 0; m_fired = 1'b0;
    e_press = 1'b0; e_release = 1'b0; e_long = 1'b0;
  endtask

  // A level change is accepted when the synchronised value has held for D+1 edges;
  // long-press counts edges spent pressed with no intervening release attempt.
  task automatic model_edge(input logic btn);
    logic p;
    p = (m_d2 == 1'b0);
    m_d2 = m_d1;
    m_d1 = btn;
    e_press = 1'b0; e_release = 1'b0; e_long = 1'b0;
    if (p == m_run_p) m_run++;
    else begin m_run = 1; m_run_p = p; end
    if (!m_lvl && p && m_run == D + 1) begin
      m_lvl = 1'b1; e_press = 1'b1; m_hold = 0; m_fired = 1'b0;
    end else if (m_lvl && !p && m_run == D + 1) begin
      m_lvl = 1'b0; e_release = 1'b1;
    end else if (m_lvl && p && m_prev_p && !m_fired) begin
      m_hold++;
      if (m_hold == L) begin e_long = 1'b1; m_fired = 1'b1; end
    end
    m_prev_p = p;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".level"},   int'(o_level),   int'(!m_lvl));
    check({tag, ".press"},   int'(o_press),   int'(e_press));
    check({tag, ".release"}, int'(o_release), int'(e_release));
    check({tag, ".long"},    int'(o_long),    int'(e_long));
  endtask

  // called at a negedge: drive, clock, update model, compare, return at next negedge
  task automatic tick(input logic btn);
    i_btn = btn;
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge(btn);
    #1;
    cyc++;
    if (o_press) press_edge = cyc;
    if (o_release) release_edge = cyc;
    if (o_long) begin long_edge = cyc; n_long++; end
    compare_all("cyc");
    @(negedge clk);
  endtask

  task automatic hold(input logic btn, input int n);
    for (int i = 0; i < n; i++) tick(btn);
  endtask

  task automatic mark();
    cyc = 0; press_edge = -1; release_edge = -1; long_edge = -1; n_long = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    i_btn = 1'b1;
    model_reset();
    mark();
    repeat (2) @(negedge clk);
    compare_all("reset");
    reset_n = 1'b1;

    // idle released
    hold(1'b1, 20);

    // clean press latency
    mark();
    hold(1'b0, 10);
    check("press_edge", press_edge, D + 3);
    hold(1'b1, 12);

    // short bounce is rejected
    mark();
    hold(1'b0, 3);
    hold(1'b1, 12);
    check("bounce_press", press_edge, -1);

    // long hold then release
    mark();
    hold(1'b0, 40);
    check("hold_press_edge", press_edge, D + 3);
    check("long_edge", long_edge, D + 3 + L);
    check("long_count", n_long, 1);
    mark();
    hold(1'b1, 12);
    check("release_edge", release_edge, D + 3);

    // glitch while pressed
    hold(1'b0, 12);
    mark();
    hold(1'b1, 2);
    hold(1'b0, 10);
    check("glitch_release", release_edge, -1);
    check("glitch_press", press_edge, -1);

    // reset mid-press with button still held
    i_btn = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("midreset");
    @(negedge clk);
    hold(1'b0, 2);
    reset_n = 1'b1;
    mark();
    hold(1'b0, 12);
    check("post_reset_press", press_edge, D + 3);

    // randomized segments, including bounces and occasional resets
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 24) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("rnd_reset");
        @(negedge clk);
        hold(logic'($urandom_range(0, 1)), $urandom_range(1, 3));
        reset_n = 1'b1;
      end else if ($urandom_range(0, 2) == 0) begin
        hold(logic'($urandom_range(0, 1)), $urandom_range(D + 2, L + 10));
      end else begin
        hold(logic'($urandom_range(0, 1)), $urandom_range(1, D + 1));
      end
    end
    hold(1'b1, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
